// File: rtl/block_transfer_sequencer.sv
// Thumb block-transfer sequencer (PUSH/POP, LDMIA/STMIA).
// Walks a latched register list one register per cycle, presenting base+4*k
// offsets to the operand-B mux, then finishes with a single base-writeback step.
// All outputs are registered; IDLE values double as reset values.
module block_transfer_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int OFFSET_WIDTH   = 12,
   parameter int REG_LIST_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [REG_LIST_WIDTH-1:0] register_list,
   input  logic                      include_extra,
   input  logic                      is_load,
   input  logic                      stall,
   output logic                      busy,
   output logic                      should_output_offset,
   output logic [OFFSET_WIDTH-1:0]   offset,
   output logic [3:0]                register_index,
   output logic                      mem_write,
   output logic                      reg_write,
   output logic                      writeback,
   output logic                      done
);

   // The largest offset is 4*9 = 36, which needs 6 bits; it must also fit the datapath.
   generate
      if (OFFSET_WIDTH < 6 || OFFSET_WIDTH > DATA_WIDTH) begin : g_bad_offset_width
         $error("block_transfer_sequencer: OFFSET_WIDTH must be in 6..DATA_WIDTH");
      end
      if (REG_LIST_WIDTH < 1 || REG_LIST_WIDTH > 8) begin : g_bad_list_width
         $error("block_transfer_sequencer: REG_LIST_WIDTH must be in 1..8");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TRANSFER  = 2'd1,
      WRITEBACK = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [REG_LIST_WIDTH-1:0] pend_q, pend_d;    // registers still to transfer after the current one
   logic                      extra_q, extra_d;  // LR/PC still pending
   logic                      load_q, load_d;
   logic [3:0]                k_q, k_d;          // zero-based step number

   logic                      busy_q, busy_d;
   logic                      soo_q, soo_d;
   logic [OFFSET_WIDTH-1:0]   offset_q, offset_d;
   logic [3:0]                idx_q, idx_d;
   logic                      memw_q, memw_d;
   logic                      regw_q, regw_d;
   logic                      wb_q, wb_d;
   logic                      done_q, done_d;

   // Next-register selection shared by the start step and every retiring step
   logic [REG_LIST_WIDTH-1:0] sel_list;
   logic                      sel_extra;
   logic                      sel_load;
   logic                      have_reg;
   logic                      have_next;
   logic [3:0]                low_idx;
   logic [3:0]                nxt_idx;
   logic [REG_LIST_WIDTH-1:0] nxt_pend;
   logic                      nxt_extra;
   logic [3:0]                k_inc;

   // Index of the lowest set bit; 0 for an empty list (caller checks emptiness).
   function automatic logic [3:0] lowest_set(input logic [REG_LIST_WIDTH-1:0] l);
      logic [3:0] r;
      r = '0;
      for (int i = REG_LIST_WIDTH - 1; i >= 0; i--) begin
         if (l[i]) r = 4'(i);
      end
      return r;
   endfunction

   // Pick the next register: ascending list bits first, then LR (store) or PC (load).
   always_comb begin
      sel_list  = (state_q == IDLE) ? register_list : pend_q;
      sel_extra = (state_q == IDLE) ? include_extra : extra_q;
      sel_load  = (state_q == IDLE) ? is_load       : load_q;
      have_reg  = |sel_list;
      have_next = have_reg | sel_extra;
      low_idx   = lowest_set(sel_list);
      nxt_idx   = have_reg ? low_idx : (sel_load ? 4'd15 : 4'd14);
      nxt_pend  = sel_list & ~(REG_LIST_WIDTH'(1) << low_idx);
      nxt_extra = have_reg ? sel_extra : 1'b0;
      k_inc     = k_q + 4'd1;
   end

   // Next-state and next-output logic; outputs default to their IDLE values.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      extra_d  = extra_q;
      load_d   = load_q;
      k_d      = k_q;
      busy_d   = 1'b0;
      soo_d    = 1'b0;
      offset_d = '0;
      idx_d    = '0;
      memw_d   = 1'b0;
      regw_d   = 1'b0;
      wb_d     = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load_d  = is_load;
               k_d     = '0;
               pend_d  = nxt_pend;
               extra_d = nxt_extra;
               busy_d  = 1'b1;
               soo_d   = 1'b1;
               if (have_next) begin
                  state_d = TRANSFER;
                  idx_d   = nxt_idx;
                  memw_d  = !is_load;
                  regw_d  = is_load;
               end else begin
                  state_d = WRITEBACK;
                  wb_d    = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         TRANSFER: begin
            if (stall) begin
               // Freeze the current step exactly as presented.
               busy_d   = busy_q;
               soo_d    = soo_q;
               offset_d = offset_q;
               idx_d    = idx_q;
               memw_d   = memw_q;
               regw_d   = regw_q;
               wb_d     = wb_q;
               done_d   = done_q;
            end else begin
               k_d      = k_inc;
               busy_d   = 1'b1;
               soo_d    = 1'b1;
               offset_d = OFFSET_WIDTH'({k_inc, 2'b00});
               if (have_next) begin
                  pend_d  = nxt_pend;
                  extra_d = nxt_extra;
                  idx_d   = nxt_idx;
                  memw_d  = !load_q;
                  regw_d  = load_q;
               end else begin
                  state_d = WRITEBACK;
                  wb_d    = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transfer immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         extra_q  <= 1'b0;
         load_q   <= 1'b0;
         k_q      <= '0;
         busy_q   <= 1'b0;
         soo_q    <= 1'b0;
         offset_q <= '0;
         idx_q    <= '0;
         memw_q   <= 1'b0;
         regw_q   <= 1'b0;
         wb_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         extra_q  <= extra_d;
         load_q   <= load_d;
         k_q      <= k_d;
         busy_q   <= busy_d;
         soo_q    <= soo_d;
         offset_q <= offset_d;
         idx_q    <= idx_d;
         memw_q   <= memw_d;
         regw_q   <= regw_d;
         wb_q     <= wb_d;
         done_q   <= done_d;
      end
   end

   assign busy                 = busy_q;
   assign should_output_offset = soo_q;
   assign offset               = offset_q;
   assign register_index       = idx_q;
   assign mem_write            = memw_q;
   assign reg_write            = regw_q;
   assign writeback            = wb_q;
   assign done                 = done_q;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer: per-cycle output vectors
// compared against hand-derived expectations.
module tb_block_transfer_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  register_list;
   logic        include_extra;
   logic        is_load;
   logic        stall;
   logic        busy;
   logic        should_output_offset;
   logic [11:0] offset;
   logic [3:0]  register_index;
   logic        mem_write;
   logic        reg_write;
   logic        writeback;
   logic        done;

   int n_checks;
   int n_fail;

   block_transfer_sequencer #(
      .DATA_WIDTH    (32),
      .OFFSET_WIDTH  (12),
      .REG_LIST_WIDTH(8)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .register_list       (register_list),
      .include_extra       (include_extra),
      .is_load             (is_load),
      .stall               (stall),
      .busy                (busy),
      .should_output_offset(should_output_offset),
      .offset              (offset),
      .register_index      (register_index),
      .mem_write           (mem_write),
      .reg_write           (reg_write),
      .writeback           (writeback),
      .done                (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Packed view: {busy, soo, offset[11:0], index[3:0], mem_write, reg_write, writeback, done}
   logic [21:0] obs;
   assign obs = {busy, should_output_offset, offset, register_index,
                 mem_write, reg_write, writeback, done};

   localparam logic [21:0] IDLE_V = 22'd0;

   function automatic logic [21:0] ev(input bit b, input bit s, input int off, input int idx,
                                      input bit mw, input bit rw, input bit wb, input bit dn);
      return {b, s, 12'(off), 4'(idx), mw, rw, wb, dn};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_checks++;
      if (obs !== IDLE_V) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, IDLE_V);
      end
      step();
      reset = 1'b1;
      step();
      n_checks++;
      if (obs !== IDLE_V) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %h expected %h", obs, IDLE_V);
      end
   endtask

   // list r0,r2 + LR store; optional 2-cycle stall on the second step
   task automatic test_store(input bit with_stall);
      logic [21:0] exp_q[$];
      exp_q.push_back(ev(1, 1, 0, 0, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 4, 2, 1, 0, 0, 0));
      if (with_stall) begin
         exp_q.push_back(ev(1, 1, 4, 2, 1, 0, 0, 0));
         exp_q.push_back(ev(1, 1, 4, 2, 1, 0, 0, 0));
      end
      exp_q.push_back(ev(1, 1, 8, 14, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 12, 0, 0, 0, 1, 1));
      exp_q.push_back(IDLE_V);
      register_list = 8'b0000_0101;
      include_extra = 1'b1;
      is_load       = 1'b0;
      start         = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            $display("FAIL store%s cyc%0d: got %h expected %h",
                     with_stall ? "_stall" : "", i, obs, exp_q[i]);
         end
         if (with_stall) stall = (i == 1 || i == 2);
         step();
      end
      stall = 1'b0;
   endtask

   task automatic test_full_load();
      logic [21:0] e;
      register_list = 8'hFF;
      include_extra = 1'b1;
      is_load       = 1'b1;
      start         = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i < 8)       e = ev(1, 1, 4 * i, i, 0, 1, 0, 0);
         else if (i == 8) e = ev(1, 1, 32, 15, 0, 1, 0, 0);
         else if (i == 9) e = ev(1, 1, 36, 0, 0, 0, 1, 1);
         else             e = IDLE_V;
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL full_load cyc%0d: got %h expected %h", i, obs, e);
         end
         step();
      end
   endtask

   task automatic test_empty();
      logic [21:0] e;
      register_list = 8'h00;
      include_extra = 1'b0;
      is_load       = 1'b0;
      start         = 1'b1;
      step();
      start = 1'b0;
      e = ev(1, 1, 0, 0, 0, 0, 1, 1);
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL empty_wb: got %h expected %h", obs, e);
      end
      step();
      n_checks++;
      if (obs !== IDLE_V) begin
         n_fail++;
         $display("FAIL empty_idle: got %h expected %h", obs, IDLE_V);
      end
      // Only PC on a load: one step then writeback of 4
      include_extra = 1'b1;
      is_load       = 1'b1;
      start         = 1'b1;
      step();
      start = 1'b0;
      e = ev(1, 1, 0, 15, 0, 1, 0, 0);
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL pc_only_step: got %h expected %h", obs, e);
      end
      step();
      e = ev(1, 1, 4, 0, 0, 0, 1, 1);
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL pc_only_wb: got %h expected %h", obs, e);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [21:0] exp_q[$];
      // first op r1,r3,r6; second op (list changed mid-op) r4..r7
      exp_q.push_back(ev(1, 1, 0, 1, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 4, 3, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 8, 6, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 12, 0, 0, 0, 1, 1));
      exp_q.push_back(IDLE_V);
      exp_q.push_back(ev(1, 1, 0, 4, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 4, 5, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 8, 6, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 12, 7, 1, 0, 0, 0));
      exp_q.push_back(ev(1, 1, 16, 0, 0, 0, 1, 1));
      exp_q.push_back(IDLE_V);
      register_list = 8'b0100_1010;
      include_extra = 1'b0;
      is_load       = 1'b0;
      start         = 1'b1;
      step();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == 0) register_list = 8'hF0;
         if (i == 5) start = 1'b0;
         n_checks++;
         if (obs !== exp_q[i]) begin
            n_fail++;
            $display("FAIL back_to_back cyc%0d: got %h expected %h", i, obs, exp_q[i]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_transfer();
      logic [21:0] e;
      register_list = 8'h0F;
      include_extra = 1'b0;
      is_load       = 1'b1;
      start         = 1'b1;
      step();
      start = 1'b0;
      step();
      e = ev(1, 1, 4, 1, 0, 1, 0, 0);
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL rst_pre_step: got %h expected %h", obs, e);
      end
      stall = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== IDLE_V) begin
         n_fail++;
         $display("FAIL rst_async: got %h expected %h", obs, IDLE_V);
      end
      step();
      stall = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (obs !== IDLE_V) begin
            n_fail++;
            $display("FAIL rst_no_done cyc%0d: got %h expected %h", i, obs, IDLE_V);
         end
         step();
      end
      register_list = 8'h03;
      is_load       = 1'b0;
      start         = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       e = ev(1, 1, 0, 0, 1, 0, 0, 0);
            1:       e = ev(1, 1, 4, 1, 1, 0, 0, 0);
            2:       e = ev(1, 1, 8, 0, 0, 0, 1, 1);
            default: e = IDLE_V;
         endcase
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rst_restart cyc%0d: got %h expected %h", i, obs, e);
         end
         step();
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      start         = 1'b0;
      register_list = 8'h00;
      include_extra = 1'b0;
      is_load       = 1'b0;
      stall         = 1'b0;
      test_reset();
      test_store(1'b0);
      test_store(1'b1);
      test_full_load();
      test_empty();
      test_back_to_back();
      test_reset_mid_transfer();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
